// File: rtl/wb_master_arbiter_pkg.sv
// Shared constants and types for the two-master pipelined Wishbone arbiter.
// Holds the FSM encodings, default limits and the debug view of arbiter state.
package wb_master_arbiter_pkg;

    localparam int MAX_OUT_DEF = 4;
    localparam int TIMEOUT_DEF = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef struct packed {
        logic [1:0] state;
        logic       last;
        logic [3:0] outstanding;
    } arb_dbg_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog: counts consecutive busy cycles without an ack and
// pulses expire for one cycle when the limit is reached.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic clear,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    // Fires in the TIMEOUT-th consecutive busy cycle, not one cycle later.
    assign expire = active & ~ack & ~clear & (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !active || ack || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master (CPU m0, DMA m1) arbiter onto one pipelined Wishbone slave,
// with an outstanding-strobe limit, round-robin ties and an ack watchdog.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_out,
    input  logic [3:0]  m0_sel,
    input  logic        m0_we,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    output logic [31:0] m0_in,
    output logic        m0_ack,
    output logic        m0_stall,
    output logic        m0_err,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_out,
    input  logic [3:0]  m1_sel,
    input  logic        m1_we,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    output logic [31:0] m1_in,
    output logic        m1_ack,
    output logic        m1_stall,
    output logic        m1_err,
    output logic [31:0] s_adr,
    output logic [31:0] s_out,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic        s_cyc,
    output logic        s_stb,
    input  logic [31:0] s_in,
    input  logic        s_ack,
    input  logic        s_stall,
    output logic [1:0]  grant,
    output logic        timeout_flag,
    output arb_dbg_t    dbg
);

    localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

    logic [1:0]  state, state_nxt;
    logic        last, last_nxt;
    logic [3:0]  outstanding, out_nxt;

    logic        own0, own1, owning;
    logic [31:0] o_adr, o_out;
    logic [3:0]  o_sel;
    logic        o_we, o_cyc, o_stb, o_stall;
    logic        accept, ack_fwd, abort, full, expire, wd_active;

    assign own0   = (state == ST_OWN0);
    assign own1   = (state == ST_OWN1);
    assign owning = own0 | own1;

    always_comb begin
        o_adr = '0;
        o_out = '0;
        o_sel = '0;
        o_we  = 1'b0;
        o_cyc = 1'b0;
        o_stb = 1'b0;
        if (own0) begin
            o_adr = m0_adr;
            o_out = m0_out;
            o_sel = m0_sel;
            o_we  = m0_we;
            o_cyc = m0_cyc;
            o_stb = m0_stb;
        end else if (own1) begin
            o_adr = m1_adr;
            o_out = m1_out;
            o_sel = m1_sel;
            o_we  = m1_we;
            o_cyc = m1_cyc;
            o_stb = m1_stb;
        end
    end

    // Handshake: a strobe is accepted in any cycle where stb=1 and stall=0;
    // each accepted strobe is retired by exactly one ack (or by abort/timeout).
    assign full    = (outstanding == MAX_OUT_L);
    assign s_adr   = o_adr;
    assign s_out   = o_out;
    assign s_sel   = o_sel;
    assign s_we    = o_we;
    assign s_cyc   = o_cyc;
    assign s_stb   = o_cyc & o_stb & (outstanding < MAX_OUT_L);
    assign accept  = s_stb & ~s_stall;
    assign ack_fwd = o_cyc & s_ack & (outstanding != 4'd0);
    assign abort   = owning & ~o_cyc;
    assign o_stall = s_stall | full;

    assign wd_active = owning & (outstanding != 4'd0);

    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .active(wd_active),
        .ack   (ack_fwd),
        .clear (abort),
        .expire(expire)
    );

    assign m0_in    = own0 ? s_in : 32'd0;
    assign m0_ack   = own0 & ack_fwd;
    assign m0_stall = own0 ? o_stall : 1'b1;
    assign m0_err   = own0 & expire;
    assign m1_in    = own1 ? s_in : 32'd0;
    assign m1_ack   = own1 & ack_fwd;
    assign m1_stall = own1 ? o_stall : 1'b1;
    assign m1_err   = own1 & expire;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = last ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc) begin
                    state_nxt = ST_OWN0;
                end else if (m1_cyc) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_nxt = outstanding;
        if (abort || expire || !owning) begin
            out_nxt = 4'd0;
        end else if (accept && !ack_fwd) begin
            out_nxt = outstanding + 4'd1;
        end else if (!accept && ack_fwd) begin
            out_nxt = outstanding - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            last         <= 1'b1;
            outstanding  <= 4'd0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            outstanding  <= out_nxt;
            timeout_flag <= timeout_flag | expire;
        end
    end

    assign grant = {own1, own0};
    assign dbg   = '{state: state, last: last, outstanding: outstanding};

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: slave model, expected-data queues
// per master, and a monitor that pops and compares on every forwarded ack.
module tb_wb_master_arbiter;
    import wb_master_arbiter_pkg::*;

    logic               clk;
    logic               rst;
    logic [1:0]         m_cyc, m_stb, m_we;
    logic [1:0][31:0]   m_adr, m_out, m_in;
    logic [1:0][3:0]    m_sel;
    logic [1:0]         m_ack, m_stall, m_err;
    logic [31:0]        s_adr, s_out, s_in;
    logic [3:0]         s_sel;
    logic               s_we, s_cyc, s_stb, s_ack, s_stall;
    logic               slv_ack, spur_ack;
    logic [1:0]         grant;
    logic               timeout_flag;
    arb_dbg_t           dbg;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_cnt = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    pend_t       pend_q[$];
    int          slv_delay = 3;
    bit          slv_mute = 0;
    int          slv_acc_cnt = 0;
    int          ack_cnt[2] = '{0, 0};
    int          err_cnt[2] = '{0, 0};
    int          stall_cnt[8];
    int          last_acc_cnt = 0;
    bit          arm = 0;
    logic [3:0]  hold = '0;
    bit          seen2 = 0;
    int          peak = 0;

    assign s_ack = slv_ack | spur_ack;

    wb_master_arbiter #(.MAX_OUT(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m_adr[0]), .m0_out(m_out[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_in(m_in[0]), .m0_ack(m_ack[0]),
        .m0_stall(m_stall[0]), .m0_err(m_err[0]),
        .m1_adr(m_adr[1]), .m1_out(m_out[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_in(m_in[1]), .m1_ack(m_ack[1]),
        .m1_stall(m_stall[1]), .m1_err(m_err[1]),
        .s_adr(s_adr), .s_out(s_out), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc),
        .s_stb(s_stb), .s_in(s_in), .s_ack(s_ack), .s_stall(s_stall),
        .grant(grant), .timeout_flag(timeout_flag), .dbg(dbg)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: run exceeded 100000 time units, required completion");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [31:0] slave_data(input logic [31:0] adr, input logic [31:0] dat,
                                               input logic [3:0] sel, input logic we);
        return adr ^ {dat[15:0], dat[31:16]} ^ {sel, 27'd0, we};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input int act, input int exp);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Slave model: acks each accepted strobe slv_delay cycles later
    initial begin
        logic        acc;
        logic [31:0] acc_data;
        slv_ack = 1'b0;
        s_in    = '0;
        forever begin
            @(negedge clk);
            acc      = s_cyc && s_stb && !s_stall;
            acc_data = slave_data(s_adr, s_out, s_sel, s_we);
            @(posedge clk);
            cyc_cnt++;
            if (acc && rst) begin
                slv_acc_cnt++;
                if (!slv_mute) pend_q.push_back('{cyc_cnt - 1 + slv_delay, acc_data});
            end
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc_cnt) begin
                slv_ack = 1'b1;
                s_in    = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                slv_ack = 1'b0;
                s_in    = '0;
            end
        end
    end

    // Scoreboard monitor: every forwarded ack pops the owner's expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (m_err[0]) err_cnt[0]++;
            if (m_err[1]) err_cnt[1]++;
            if (m_ack[0]) begin
                ack_cnt[0]++;
                if (exp_q0.size() == 0) flag_fail("ack_m0_unexpected", 1, 0);
                else check("ack_data_m0", m_in[0], exp_q0.pop_front());
            end
            if (m_ack[1]) begin
                ack_cnt[1]++;
                if (exp_q1.size() == 0) flag_fail("ack_m1_unexpected", 1, 0);
                else check("ack_data_m1", m_in[1], exp_q1.pop_front());
            end
        end
    end

    // Accept and forwarded ack in one cycle must leave the count unchanged
    initial begin
        forever begin
            @(negedge clk);
            if (arm && rst) check("out_same_cycle", 32'(dbg.outstanding), 32'(hold));
            arm = 1'b0;
            if (rst && s_stb && !s_stall && (m_ack != 2'b00)) begin
                arm  = 1'b1;
                hold = dbg.outstanding;
                if (hold == 4'd2) seen2 = 1'b1;
            end
            if (int'(dbg.outstanding) > peak) peak = int'(dbg.outstanding);
        end
    end

    task automatic issue(input int m, input int n, input logic [31:0] base, input bit push);
        int  budget;
        bit  stuck;
        m_cyc[m] = 1'b1;
        stuck    = 1'b0;
        for (int i = 0; i < n && !stuck; i++) begin
            m_stb[m] = 1'b1;
            m_adr[m] = base + 32'(i * 4);
            m_out[m] = 32'hD000_0000 + 32'(i) * 32'h0101_0101;
            m_sel[m] = 4'(1 << (i % 4));
            m_we[m]  = i[0];
            stall_cnt[i] = 0;
            budget = 0;
            forever begin
                @(negedge clk);
                if (!m_stall[m]) break;
                stall_cnt[i]++;
                budget++;
                if (budget > 200) begin
                    flag_fail("stall_wait", budget, 0);
                    stuck = 1'b1;
                    break;
                end
            end
            if (!stuck) begin
                last_acc_cnt = cyc_cnt;
                if (push) begin
                    if (m == 0) exp_q0.push_back(slave_data(m_adr[m], m_out[m], m_sel[m], m_we[m]));
                    else        exp_q1.push_back(slave_data(m_adr[m], m_out[m], m_sel[m], m_we[m]));
                end
            end
            @(posedge clk);
            #1;
        end
        m_stb[m] = 1'b0;
    endtask

    task automatic drain(input int m, input int limit);
        int t;
        t = 0;
        while ((m == 0 ? exp_q0.size() : exp_q1.size()) != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > limit) begin
                flag_fail("drain_pending", (m == 0 ? exp_q0.size() : exp_q1.size()), 0);
                if (m == 0) exp_q0.delete();
                else        exp_q1.delete();
                break;
            end
        end
    endtask

    initial begin
        int t;
        int base;
        rst      = 1'b0;
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        m_we     = '0;
        m_adr    = '0;
        m_out    = '0;
        m_sel    = '0;
        s_stall  = 1'b0;
        spur_ack = 1'b0;

        // Reset state with m0 requesting
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_stall", 32'(m_stall), 32'd3);
        check("rst_ack", 32'(m_ack), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
        check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
        check("rst_outstanding", 32'(dbg.outstanding), 32'd0);

        // Simultaneous request after reset: m0 wins, one idle cycle, then m1
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_stb = 2'b00;
        m_cyc = 2'b11;
        @(negedge clk);
        check("grant_latency", 32'(grant), 32'd0);
        @(negedge clk);
        check("tie_after_reset", 32'(grant), 32'd1);
        check("grant_s_cyc", 32'(s_cyc), 32'd1);
        check("non_owner_stall", 32'(m_stall[1]), 32'd1);
        repeat (3) @(negedge clk);
        check("no_preempt", 32'(grant), 32'd1);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        @(negedge clk);
        check("abort_s_cyc", 32'(s_cyc), 32'd0);
        @(negedge clk);
        check("idle_before_regrant", 32'(grant), 32'd0);
        @(negedge clk);
        check("regrant_m1", 32'(grant), 32'd2);

        // m1 traffic with the slave stalling the first three cycles
        @(posedge clk);
        #1;
        slv_delay = 3;
        s_stall   = 1'b1;
        fork
            issue(1, 3, 32'h0000_0100, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                s_stall = 1'b0;
            end
        join
        check("slave_stall_pass", 32'(stall_cnt[0]), 32'd3);
        drain(1, 100);
        m_cyc[1] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Six back-to-back strobes, ack latency 10, limit 4 outstanding
        slv_delay = 10;
        base = slv_acc_cnt;
        fork
            issue(0, 6, 32'h0000_0200, 1'b1);
            begin
                t = 0;
                forever begin
                    @(negedge clk);
                    if (m_ack[0]) break;
                    t++;
                    if (t > 100) begin
                        flag_fail("first_ack_wait", t, 0);
                        break;
                    end
                end
                check("accepts_before_first_ack", 32'(slv_acc_cnt - base), 32'd4);
                check("stall_until_first_ack", 32'(m_stall[0]), 32'd1);
            end
        join
        check("fifth_stall_cycles", 32'(stall_cnt[4]), 32'd7);
        check("peak_outstanding", 32'(peak), 32'd4);
        drain(0, 100);
        check("m0_ack_total_6", 32'(ack_cnt[0]), 32'd6);

        // Round robin: after m0 releases, a tie goes to m1
        m_cyc[0] = 1'b0;
        @(posedge clk);
        #1;
        m_cyc = 2'b11;
        @(negedge clk);
        check("rr_idle", 32'(grant), 32'd0);
        @(negedge clk);
        check("tie_round_robin", 32'(grant), 32'd2);
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b0;

        // Ack latency 2 forces accept+ack with two outstanding
        slv_delay = 2;
        seen2     = 1'b0;
        issue(0, 4, 32'h0000_0300, 1'b1);
        drain(0, 100);
        check("same_cycle_at_2_seen", 32'(seen2), 32'd1);

        // Watchdog: one strobe never acked
        slv_mute = 1'b1;
        issue(0, 1, 32'h0000_0400, 1'b0);
        t = 0;
        forever begin
            @(negedge clk);
            if (m_err[0]) break;
            t++;
            if (t > 400) begin
                flag_fail("err_wait", t, 255);
                break;
            end
        end
        check("err_latency", 32'(cyc_cnt - last_acc_cnt), 32'd255);
        @(negedge clk);
        check("err_single_cycle", 32'(m_err[0]), 32'd0);
        check("timeout_flag_set", 32'(timeout_flag), 32'd1);
        check("timeout_clears_out", 32'(dbg.outstanding), 32'd0);
        check("timeout_keeps_state", 32'(grant), 32'd1);

        // Spurious slave ack with nothing outstanding
        @(posedge clk);
        #1;
        spur_ack = 1'b1;
        @(negedge clk);
        check("spurious_ack_dropped", 32'(m_ack[0]), 32'd0);
        check("spurious_out_0", 32'(dbg.outstanding), 32'd0);
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        slv_mute = 1'b0;
        @(negedge clk);
        check("spurious_out_after", 32'(dbg.outstanding), 32'd0);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Asynchronous reset with three strobes outstanding in OWN1
        slv_delay = 20;
        issue(1, 3, 32'h0000_0500, 1'b1);
        @(negedge clk);
        check("three_outstanding", 32'(dbg.outstanding), 32'd3);
        check("flag_sticky", 32'(timeout_flag), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("reset_abort_grant", 32'(grant), 32'd0);
        check("reset_abort_s_cyc", 32'(s_cyc), 32'd0);
        check("reset_abort_stall", 32'(m_stall), 32'd3);
        check("reset_abort_out", 32'(dbg.outstanding), 32'd0);
        check("reset_clears_flag", 32'(timeout_flag), 32'd0);
        exp_q1.delete();
        m_cyc = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(grant), 32'd0);
        @(negedge clk);
        check("tie_after_reset_abort", 32'(grant), 32'd1);
        repeat (25) @(negedge clk);
        check("stale_acks_dropped", 32'(dbg.outstanding), 32'd0);
        check("m0_ack_total", 32'(ack_cnt[0]), 32'd10);
        check("m1_ack_total", 32'(ack_cnt[1]), 32'd3);
        check("m0_err_pulses", 32'(err_cnt[0]), 32'd1);
        check("m1_err_pulses", 32'(err_cnt[1]), 32'd0);
        @(posedge clk);
        #1;
        m_cyc = 2'b00;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
